// File: rtl/ws2812_pkg.sv
// ============================================================================
// Module   : ws2812_pkg
// Brief    : WS2812 bit timing defaults and serializer state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package ws2812_pkg;

  localparam int CYCLES_PER_BIT  = 15;
  localparam int T0H_CYCLES      = 5;
  localparam int T1H_CYCLES      = 10;
  localparam int BITS_PER_PIXEL  = 24;
  // Window the frame controller reserves for one pixel.
  localparam int TRANSMIT_CYCLES = BITS_PER_PIXEL * CYCLES_PER_BIT;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_SHIFT  = 2'd2
  } ws2812_state_e;

endpackage

`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
// ============================================================================
// Module   : ws2812_bit_timer
// Brief    : Bit-cell cycle counter with high-time compare for one WS2812 bit
// Revision : 1.0
// ============================================================================
`default_nettype none

module ws2812_bit_timer #(
  parameter int CYCLES_PER_BIT = ws2812_pkg::CYCLES_PER_BIT,
  parameter int T0H_CYCLES     = ws2812_pkg::T0H_CYCLES,
  parameter int T1H_CYCLES     = ws2812_pkg::T1H_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic advance_i,
  input  logic bit_val_i,
  output logic bit_end_o,
  output logic level_o
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] T0H_CNT  = CNT_W'(T0H_CYCLES);
  localparam logic [CNT_W-1:0] T1H_CNT  = CNT_W'(T1H_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (advance_i) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = advance_i && (cnt_q == LAST_CNT);
  assign level_o   = cnt_q < (bit_val_i ? T1H_CNT : T0H_CNT);

endmodule

`default_nettype wire

// File: rtl/ws2812_serializer.sv
// ============================================================================
// Module   : ws2812_serializer
// Brief    : Serializes one GRB pixel onto the WS2812 NRZ data line
// Revision : 1.0
// ============================================================================
`default_nettype none

module ws2812_serializer #(
  parameter int CYCLES_PER_BIT = ws2812_pkg::CYCLES_PER_BIT,
  parameter int T0H_CYCLES     = ws2812_pkg::T0H_CYCLES,
  parameter int T1H_CYCLES     = ws2812_pkg::T1H_CYCLES,
  parameter int BITS_PER_PIXEL = ws2812_pkg::BITS_PER_PIXEL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_sreg_i,
  input  logic       transmit_pixel_i,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  output logic       dout_o,
  output logic       pixel_done_o,
  output logic       busy_o,
  output logic       overrun_o,
  output logic       underrun_o
);

  import ws2812_pkg::*;

  localparam int BIT_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_PIXEL - 1);

  ws2812_state_e    state_q, state_d;
  logic [23:0]      shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dout_q, dout_d;
  logic             fin_q, fin_d;
  logic             pixel_done_q;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             underrun_q, underrun_d;
  logic             completed_q, completed_d;

  logic timer_clear;
  logic timer_adv;
  logic bit_end;
  logic bit_level;

  ws2812_bit_timer #(
    .CYCLES_PER_BIT (CYCLES_PER_BIT),
    .T0H_CYCLES     (T0H_CYCLES),
    .T1H_CYCLES     (T1H_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (timer_clear),
    .advance_i (timer_adv),
    .bit_val_i (shreg_q[23]),
    .bit_end_o (bit_end),
    .level_o   (bit_level)
  );

  // fin_q marks the cycle after the last bit cell was sampled; pixel_done and
  // the fall of busy line up with the first idle-low dout cycle.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    dout_d      = 1'b0;
    fin_d       = 1'b0;
    busy_d      = fin_q ? 1'b0 : busy_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    completed_d = completed_q;
    timer_clear = 1'b0;
    timer_adv   = 1'b0;

    if (load_sreg_i) begin
      state_d     = ST_LOADED;
      shreg_d     = {green_i, red_i, blue_i};
      bit_cnt_d   = '0;
      busy_d      = 1'b1;
      completed_d = 1'b0;
      timer_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (transmit_pixel_i) begin
            if (completed_q) begin
              overrun_d = 1'b1;
            end else begin
              underrun_d = 1'b1;
            end
          end
        end
        ST_LOADED, ST_SHIFT: begin
          if (transmit_pixel_i) begin
            timer_adv = 1'b1;
            dout_d    = bit_level;
            state_d   = ST_SHIFT;
            if (bit_end) begin
              shreg_d = {shreg_q[22:0], 1'b0};
              if (bit_cnt_q == LAST_BIT) begin
                state_d     = ST_IDLE;
                bit_cnt_d   = '0;
                fin_d       = 1'b1;
                completed_d = 1'b1;
              end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= 1'b0;
      fin_q        <= 1'b0;
      pixel_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      completed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      fin_q        <= fin_d;
      pixel_done_q <= fin_q;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      completed_q  <= completed_d;
    end
  end

  assign dout_o       = dout_q;
  assign pixel_done_o = pixel_done_q;
  assign busy_o       = busy_q;
  assign overrun_o    = overrun_q;
  assign underrun_o   = underrun_q;

endmodule

`default_nettype wire
